// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_pkg
//  Description : Shared definitions for the TDM link (frame format, FSM
//                states). Used by both the receive demultiplexer and the
//                transmit serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
package tdm_pkg;

   // Default number of TDM slots per frame
   localparam int LANES_DEFAULT = 8;

   // Frame alignment state
   typedef enum logic [0:0] {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } tdm_state_t;

endpackage : tdm_pkg
`default_nettype wire

// File: rtl/tdm_slot_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_slot_ctr
//  Description : Slot index counter for the TDM receiver. Supports clear to
//                slot 0, load to slot 1 (frame start bit already consumed),
//                and increment with natural wrap at LANES.
//  Revision    : 1.0 - initial release
// ============================================================================
module tdm_slot_ctr
   import tdm_pkg::*;
#(
   parameter int LANES = LANES_DEFAULT,
   parameter int SW    = $clog2(LANES)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inc,
   input  logic          load1,
   input  logic          clr,
   output logic [SW-1:0] cnt,
   output logic          last
);

   logic [SW-1:0] r_cnt;

   // Counter register: clear wins over load, load wins over increment.
   // LANES is a power of two, so the plain increment wraps to slot 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (load1) begin
         r_cnt <= SW'(1);
      end else if (inc) begin
         r_cnt <= r_cnt + SW'(1);
      end
   end

   assign cnt  = r_cnt;
   assign last = (r_cnt == SW'(LANES - 1));

endmodule : tdm_slot_ctr
`default_nettype wire

// File: rtl/tdm_demux8.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_demux8
//  Description : Serial-to-parallel TDM demultiplexer. Hunts for the
//                start-of-frame marker, collects one bit per slot into a
//                shadow register and publishes complete frames on dout with
//                a one-cycle frame_valid pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tdm_demux8
   import tdm_pkg::*;
#(
   parameter int LANES = LANES_DEFAULT,
   parameter int SW    = $clog2(LANES)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             din,
   input  logic             din_valid,
   input  logic             sof,
   output logic [LANES-1:0] dout,
   output logic             frame_valid,
   output logic [SW-1:0]    slot,
   output logic             locked,
   output logic             sync_err
);

   tdm_state_t       r_state;
   tdm_state_t       w_next_state;
   logic [LANES-1:0] r_shadow;
   logic [LANES-1:0] r_dout;
   logic             r_frame_valid;
   logic             r_sync_err;
   logic             r_locked;

   logic [SW-1:0]    w_slot;
   logic             w_last;
   logic             w_ctr_inc;
   logic             w_ctr_load1;
   logic             w_ctr_clr;
   logic             w_wr_en;
   logic [SW-1:0]    w_wr_idx;
   logic             w_frame_done;
   logic             w_err;

   tdm_slot_ctr #(
      .LANES (LANES),
      .SW    (SW)
   ) u_slot_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_ctr_inc),
      .load1 (w_ctr_load1),
      .clr   (w_ctr_clr),
      .cnt   (w_slot),
      .last  (w_last)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= HUNT;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state and per-bit decisions; idle cycles (din_valid=0) change nothing
   always_comb begin
      w_next_state = r_state;
      w_ctr_inc    = 1'b0;
      w_ctr_load1  = 1'b0;
      w_ctr_clr    = 1'b0;
      w_wr_en      = 1'b0;
      w_wr_idx     = w_slot;
      w_frame_done = 1'b0;
      w_err        = 1'b0;
      if (din_valid) begin
         case (r_state)
            HUNT: begin
               if (sof) begin
                  w_wr_en      = 1'b1;
                  w_wr_idx     = '0;
                  w_ctr_load1  = 1'b1;
                  w_next_state = LOCKED;
               end
            end
            LOCKED: begin
               if (sof) begin
                  // Marker anywhere but slot 0 abandons the partial frame
                  w_err       = (w_slot != '0);
                  w_wr_en     = 1'b1;
                  w_wr_idx    = '0;
                  w_ctr_load1 = 1'b1;
               end else if (w_slot == '0) begin
                  // Missing marker: alignment lost, drop the bit
                  w_err        = 1'b1;
                  w_ctr_clr    = 1'b1;
                  w_next_state = HUNT;
               end else begin
                  w_wr_en      = 1'b1;
                  w_ctr_inc    = 1'b1;
                  w_frame_done = w_last;
               end
            end
            default: begin
               w_next_state = HUNT;
            end
         endcase
      end
   end

   // Shadow register collects the frame in progress
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_shadow <= '0;
      end else if (w_wr_en) begin
         r_shadow[w_wr_idx] <= din;
      end
   end

   // Output frame register; the last bit bypasses the shadow so the whole
   // frame lands in one update
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_dout <= '0;
      end else if (w_frame_done) begin
         r_dout <= {din, r_shadow[LANES-2:0]};
      end
   end

   // Registered status pulses and lock indication
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_frame_valid <= 1'b0;
         r_sync_err    <= 1'b0;
         r_locked      <= 1'b0;
      end else begin
         r_frame_valid <= w_frame_done;
         r_sync_err    <= w_err;
         r_locked      <= (w_next_state == LOCKED);
      end
   end

   assign dout        = r_dout;
   assign frame_valid = r_frame_valid;
   assign sync_err    = r_sync_err;
   assign locked      = r_locked;
   assign slot        = w_slot;

endmodule : tdm_demux8
`default_nettype wire

// File: tb/tb_tdm_demux8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tdm_demux8
//  Description : Self-checking bench for tdm_demux8 with a queue-based frame
//                model and directed frame scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tdm_demux8;

   localparam int LANES = 8;
   localparam int SW    = 3;

   logic             clk;
   logic             rst_n;
   logic             din;
   logic             din_valid;
   logic             sof;
   logic [LANES-1:0] dout;
   logic             frame_valid;
   logic [SW-1:0]    slot;
   logic             locked;
   logic             sync_err;

   int n_checks = 0;
   int n_fail   = 0;
   int n_fv     = 0;
   int n_err    = 0;

   tdm_demux8 #(.LANES(LANES)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .din         (din),
      .din_valid   (din_valid),
      .sof         (sof),
      .dout        (dout),
      .frame_valid (frame_valid),
      .slot        (slot),
      .locked      (locked),
      .sync_err    (sync_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Behavioural model: the frame in progress is a queue of received bits
   bit             m_buf[$];
   bit             m_aligned = 1'b0;
   bit [LANES-1:0] m_dout    = '0;
   bit             m_fv      = 1'b0;
   bit             m_err     = 1'b0;
   bit             m_started = 1'b0;

   always @(posedge clk) begin
      m_started = 1'b1;
      m_fv      = 1'b0;
      m_err     = 1'b0;
      if (!rst_n) begin
         m_buf.delete();
         m_aligned = 1'b0;
         m_dout    = '0;
      end else if (din_valid) begin
         if (!m_aligned) begin
            if (sof) begin
               m_buf.delete();
               m_buf.push_back(din);
               m_aligned = 1'b1;
            end
         end else if (sof) begin
            m_err = (m_buf.size() != 0);
            m_buf.delete();
            m_buf.push_back(din);
         end else if (m_buf.size() == 0) begin
            m_err     = 1'b1;
            m_aligned = 1'b0;
         end else begin
            m_buf.push_back(din);
            if (m_buf.size() == LANES) begin
               for (int k = 0; k < LANES; k++) m_dout[k] = m_buf[k];
               m_fv = 1'b1;
               m_buf.delete();
            end
         end
      end
   end

   // Compare process: every cycle, away from the active edge
   always @(negedge clk) begin
      if (m_started) begin
         chk("dout",        32'(dout),        32'(m_dout));
         chk("frame_valid", 32'(frame_valid), 32'(m_fv));
         chk("sync_err",    32'(sync_err),    32'(m_err));
         chk("locked",      32'(locked),      32'(m_aligned));
         chk("slot",        32'(slot),        32'(m_buf.size()));
         if (frame_valid === 1'b1) n_fv++;
         if (sync_err === 1'b1) n_err++;
      end
   end

   task automatic send_bit(input logic d, input logic s);
      din       = d;
      sof       = s;
      din_valid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) begin
         din       = 1'($urandom_range(1));
         sof       = 1'($urandom_range(1));
         din_valid = 1'b0;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [LANES-1:0] v);
      for (int i = 0; i < LANES; i++) send_bit(v[i], i == 0);
   endtask

   initial begin
      logic [7:0] pre;
      rst_n     = 1'b0;
      din       = 1'b0;
      din_valid = 1'b0;
      sof       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_dout",   32'(dout),   32'h0);
      chk("reset_locked", 32'(locked), 32'h0);
      chk("reset_slot",   32'(slot),   32'h0);
      rst_n = 1'b1;
      gap(2);

      // Single frame A5, bits 1,0,1,0,0,1,0,1
      send_frame(8'hA5);
      chk("a5_fv",     32'(frame_valid), 32'h1);
      chk("a5_dout",   32'(dout),        32'hA5);
      chk("a5_locked", 32'(locked),      32'h1);

      // Back-to-back frames
      send_frame(8'h01);
      chk("b2b_01", 32'(dout), 32'h01);
      send_frame(8'h80);
      chk("b2b_80", 32'(dout), 32'h80);
      send_frame(8'hFF);
      chk("b2b_ff", 32'(dout), 32'hFF);
      chk("b2b_fv", 32'(frame_valid), 32'h1);

      // Frame 3C with 5 idle cycles inside it
      pre = 8'h3C;
      for (int i = 0; i < LANES; i++) begin
         send_bit(pre[i], i == 0);
         if (i == 2) gap(2);
         if (i == 5) gap(3);
      end
      chk("gap_3c", 32'(dout), 32'h3C);

      // Early marker at slot 5: partial frame dropped, C3 completes
      pre = 8'h96;
      for (int i = 0; i < 5; i++) send_bit(pre[i], i == 0);
      chk("early_slot", 32'(slot), 32'h5);
      send_bit(1'b1, 1'b1);
      chk("early_err", 32'(sync_err), 32'h1);
      chk("early_nofv_dout", 32'(dout), 32'h3C);
      pre = 8'hC3;
      for (int i = 1; i < LANES; i++) send_bit(pre[i], 1'b0);
      chk("early_c3", 32'(dout), 32'hC3);

      // Good frame then missing marker
      send_frame(8'h96);
      send_bit(1'b1, 1'b0);
      chk("miss_err",    32'(sync_err), 32'h1);
      chk("miss_locked", 32'(locked),   32'h0);
      for (int i = 0; i < 7; i++) send_bit(i[0], 1'b0);
      chk("miss_dout", 32'(dout), 32'h96);
      chk("miss_slot", 32'(slot), 32'h0);

      // Reset in the middle of a frame, then 5A
      pre = 8'hE7;
      for (int i = 0; i < 4; i++) send_bit(pre[i], i == 0);
      rst_n = 1'b0;
      gap(2);
      chk("midrst_dout",   32'(dout),   32'h0);
      chk("midrst_locked", 32'(locked), 32'h0);
      rst_n = 1'b1;
      send_frame(8'h5A);
      chk("post_rst_5a", 32'(dout), 32'h5A);
      chk("post_rst_fv", 32'(frame_valid), 32'h1);
      gap(3);

      // Totals: A5,01,80,FF,3C,C3,96,5A frames; early + missing marker errors
      chk("fv_count",  32'(n_fv),  32'd8);
      chk("err_count", 32'(n_err), 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_tdm_demux8
`default_nettype wire

// File: doc/tdm_demux8.md
# tdm_demux8

Serial-to-parallel time-division demultiplexer: receives a 1-bit TDM stream produced by the 8:1 multiplexer path (one lane per slot, slot 0 first) and distributes each bit back to its lane. It tracks frame alignment with a start-of-frame marker and presents one complete, registered N-bit parallel frame at a time. It sits at the receive end of the multiplexed link, feeding lane-parallel logic.

## Interface
Parameters:
- LANES, default 8, number of TDM slots per frame; power of two, 2..64.
- SW, default $clog2(LANES), slot index width; derived, not overridden.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- din  input  1  serial data bit.
- din_valid  input  1  din and sof are meaningful this cycle; low = stall, no slot consumed.
- sof  input  1  qualified by din_valid; marks the slot-0 bit of a frame.
- dout  output  LANES  last complete frame; bit k = slot k.
- frame_valid  output  1  one-cycle pulse when dout is updated.
- slot  output  SW  slot index the next valid bit will be written to.
- locked  output  1  high while aligned to the frame.
- sync_err  output  1  one-cycle pulse on an alignment violation.

## Operation
- Two-state FSM: HUNT, LOCKED. Reset state HUNT.
- HUNT: bits with din_valid=1, sof=0 are discarded. On din_valid=1, sof=1: write din to shadow[0], slot←1, go LOCKED.
- LOCKED, din_valid=1:
  - slot≠0, sof=0: shadow[slot]←din, slot←slot+1 (mod LANES).
  - slot=LANES-1, sof=0: in addition, dout←{din, shadow[LANES-2:0]} and frame_valid pulses next cycle; slot wraps to 0.
  - slot=0, sof=1: shadow[0]←din, slot←1 (normal frame start).
  - slot≠0, sof=1 (early marker): sync_err pulses; partial frame discarded; bit treated as new slot 0 (shadow[0]←din, slot←1); stay LOCKED.
  - slot=0, sof=0 (missing marker): sync_err pulses; bit discarded; slot←0; go HUNT.
- din_valid=0: no state change. Gaps of any length are allowed mid-frame.
- dout holds its value until the next complete frame. It is never partially updated.
- Shadow register contents are don't-care outside the current frame. dout bits are never sourced from a previous frame.

## Timing
- Reset values (rst_n=0 at a clock edge): dout=0, frame_valid=0, sync_err=0, locked=0, slot=0, state=HUNT, shadow=0.
- Reset mid-frame: partial frame discarded; dout cleared; first frame after reset requires sof.
- Latency: last bit (slot LANES-1) sampled at edge t → dout and frame_valid visible after edge t, for one cycle (frame_valid); dout persists.
- Minimum frame period LANES valid cycles; back-to-back frames give frame_valid every LANES cycles with no bubble.
- locked is a registered copy of state==LOCKED. It rises the cycle after the accepted sof and falls the cycle after a missing-marker error.
- sync_err is registered, coincident with the state or slot update it reports. Never asserted in HUNT.
- slot reflects the registered counter; 0 in HUNT.

## Structure
- Package tdm_pkg: FSM state enum (HUNT, LOCKED) and the default LANES constant. Shared with the transmit-side serializer the team builds against the same frame format.
- One sub-module: tdm_slot_ctr, a SW-bit counter with sync active-low reset, increment enable, load-to-1, clear-to-0 and last-slot flag. The remainder (FSM, shadow, output register) stays in tdm_demux8.

## Test plan
- Reset then frame 8'hA5 sent slot 0 first (bits 1,0,1,0,0,1,0,1) with sof on first, din_valid continuous → frame_valid pulse one cycle after 8th bit, dout=8'hA5, locked=1, sync_err never.
- Three back-to-back frames 8'h01, 8'h80, 8'hFF → frame_valid every 8 cycles, dout sequence 01, 80, FF, no missed or extra pulses.
- Frame 8'h3C with din_valid low for 5 random cycles mid-frame → identical result to the gap-free case; slot frozen during gaps.
- sof reasserted at slot 5, followed by 7 more bits forming 8'hC3 → sync_err one pulse, no frame_valid for the partial frame, dout=8'hC3 after completion.
- After a good frame, slot-0 bit arrives without sof → sync_err pulse, locked falls, following bits ignored until sof; dout keeps the old frame.
- rst_n low at slot 4 of a frame, then a full frame 8'h5A → all outputs 0 during reset, first frame_valid shows dout=8'h5A.
